// File: rtl/sram_arbiter.sv
// Two-requester (fetch/data) arbiter onto one sram-like port with in-order response routing.
// Optional macro SRAM_ARB_RR_EN selects round-robin instead of data-first priority.
module sram_arbiter #(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    input  logic [1:0]  inst_size,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,
    output logic        arb_err
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned NSLOT = 1 << PW;

    logic [CW-1:0]    count_q, count_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [NSLOT-1:0] tags_q, tags_d;
    logic             lock_q, lock_d;
    logic             lock_owner_q, lock_owner_d;
    logic             arb_err_q, arb_err_d;
`ifdef SRAM_ARB_RR_EN
    logic             last_q, last_d;
`endif

    logic grant_data_c;
    logic mem_req_c;
    logic push_c;
    logic pop_c;
    logic head_tag_c;
    logic full_c;

    function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Grant selection: a stalled owner keeps the port while it still requests.
    always_comb begin
        grant_data_c = data_req;
        if (lock_q && (lock_owner_q ? data_req : inst_req)) begin
            grant_data_c = lock_owner_q;
        end else if (inst_req && data_req) begin
`ifdef SRAM_ARB_RR_EN
            grant_data_c = ~last_q;
`else
            grant_data_c = 1'b1;
`endif
        end
    end

    assign full_c     = (count_q == CW'(DEPTH));
    assign mem_req_c  = (inst_req | data_req) & ~full_c & ~reset;
    assign push_c     = mem_req_c & mem_addr_ok;
    assign pop_c      = mem_data_ok & (count_q != '0) & ~reset;
    assign head_tag_c = tags_q[rd_ptr_q];

    assign mem_req      = mem_req_c;
    assign mem_wr       = mem_req_c & grant_data_c & data_wr;
    assign mem_size     = mem_req_c ? (grant_data_c ? data_size : inst_size) : 2'b00;
    assign mem_wstrb    = (mem_req_c & grant_data_c) ? data_wstrb : 4'b0000;
    assign mem_addr     = mem_req_c ? (grant_data_c ? data_addr : inst_addr) : 32'h0;
    assign mem_wdata    = (mem_req_c & grant_data_c) ? data_wdata : 32'h0;
    assign inst_addr_ok = mem_req_c & ~grant_data_c & mem_addr_ok;
    assign data_addr_ok = mem_req_c & grant_data_c & mem_addr_ok;
    assign inst_data_ok = pop_c & ~head_tag_c;
    assign data_data_ok = pop_c & head_tag_c;
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;
    assign arb_err      = arb_err_q;

    // Source-tag FIFO, lock, error and last-winner next state.
    always_comb begin
        count_d      = count_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        tags_d       = tags_q;
        lock_d       = mem_req_c & ~mem_addr_ok;
        lock_owner_d = grant_data_c;
        arb_err_d    = arb_err_q;
`ifdef SRAM_ARB_RR_EN
        last_d       = last_q;
`endif
        if (push_c) begin
            tags_d[wr_ptr_q] = grant_data_c;
            wr_ptr_d         = inc_ptr(wr_ptr_q);
`ifdef SRAM_ARB_RR_EN
            last_d           = grant_data_c;
`endif
        end
        if (pop_c) begin
            rd_ptr_d = inc_ptr(rd_ptr_q);
        end
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (mem_data_ok && (count_q == '0)) begin
            arb_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            tags_q       <= '0;
            lock_q       <= 1'b0;
            lock_owner_q <= 1'b0;
            arb_err_q    <= 1'b0;
`ifdef SRAM_ARB_RR_EN
            last_q       <= 1'b0;
`endif
        end else begin
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            tags_q       <= tags_d;
            lock_q       <= lock_d;
            lock_owner_q <= lock_owner_d;
            arb_err_q    <= arb_err_d;
`ifdef SRAM_ARB_RR_EN
            last_q       <= last_d;
`endif
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: directed scenarios plus randomized traffic against a queue-based model.
module tb_sram_arbiter;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_addr_ok, inst_data_ok;
    logic [31:0] inst_addr, inst_rdata;
    logic [1:0]  inst_size;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        arb_err;

    always #5 clk = ~clk;

    sram_arbiter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_size(inst_size),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
        .arb_err(arb_err)
    );

    typedef struct {
        bit          tag;
        logic [31:0] rd;
        int          cyc;
    } sb_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model state: outstanding tags in acceptance order, stall owner, last winner.
    int          cnt;
    bit          tq[$];
    bit          lk_v, lk_o, last, err_m;
    sb_t         sb[$];
    logic [31:0] alog[$];
    sb_t         rlog[$];
    bit          acc_f, acc_d;
    logic        seen_req, seen_err;
    logic [31:0] seen_addr;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: check request side at the falling edge, advance the model, return after the rising edge.
    task automatic step();
        bit          gd, mreq, acc, pop;
        logic [31:0] e_addr;
        sb_t         e;
        @(negedge clk);
        if (lk_v && (lk_o ? data_req : inst_req)) gd = lk_o;
        else if (inst_req && data_req) begin
`ifdef SRAM_ARB_RR_EN
            gd = ~last;
`else
            gd = 1'b1;
`endif
        end else gd = data_req;
        mreq   = !reset && (inst_req || data_req) && (cnt < DEPTH);
        e_addr = !mreq ? 32'h0 : (gd ? data_addr : inst_addr);
        chk1("mem_req", mem_req, mreq);
        chk32("mem_addr", mem_addr, e_addr);
        chk1("mem_wr", mem_wr, mreq && gd && data_wr);
        chk32("mem_size", 32'(mem_size), !mreq ? 32'h0 : 32'(gd ? data_size : inst_size));
        chk32("mem_wstrb", 32'(mem_wstrb), (mreq && gd) ? 32'(data_wstrb) : 32'h0);
        chk32("mem_wdata", mem_wdata, (mreq && gd) ? data_wdata : 32'h0);
        chk1("inst_addr_ok", inst_addr_ok, mreq && !gd && mem_addr_ok);
        chk1("data_addr_ok", data_addr_ok, mreq && gd && mem_addr_ok);
        chk1("arb_err", arb_err, err_m);
        chk1("rdata_pass", (inst_rdata === mem_rdata) && (data_rdata === mem_rdata), 1'b1);
        seen_req  = mem_req;
        seen_err  = arb_err;
        seen_addr = mem_addr;
        if (mem_req && mem_addr_ok) alog.push_back(mem_addr);
        acc   = mreq && mem_addr_ok;
        pop   = !reset && mem_data_ok && (cnt > 0);
        acc_f = acc && !gd;
        acc_d = acc && gd;
        if (pop) begin
            e.tag = tq.pop_front();
            e.rd  = mem_rdata;
            e.cyc = cyc;
            sb.push_back(e);
        end
        if (!reset && mem_data_ok && cnt == 0) err_m = 1'b1;
        if (acc) begin
            tq.push_back(gd);
            last = gd;
        end
        lk_v = mreq && !mem_addr_ok;
        lk_o = gd;
        cnt  = cnt + int'(acc) - int'(pop);
        if (reset) begin
            cnt = 0; tq.delete(); lk_v = 0; last = 0; err_m = 0; sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // Response monitor: any data_ok must match the head of the scoreboard for this cycle.
    initial begin
        sb_t e;
        bit  exp_pulse;
        forever begin
            @(negedge clk);
            #2;
            exp_pulse = (sb.size() > 0) && (sb[0].cyc == cyc);
            chk1("data_ok_present", inst_data_ok | data_data_ok, exp_pulse);
            chk1("data_ok_onehot", inst_data_ok & data_data_ok, 1'b0);
            if (exp_pulse) begin
                e = sb.pop_front();
                if (inst_data_ok || data_data_ok) begin
                    chk1("data_ok_route", data_data_ok, e.tag);
                    chk32("resp_rdata", data_data_ok ? data_rdata : inst_rdata, e.rd);
                end
            end
            if (inst_data_ok || data_data_ok) begin
                e.tag = data_data_ok;
                e.rd  = data_data_ok ? data_rdata : inst_rdata;
                e.cyc = cyc;
                rlog.push_back(e);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic idle();
        inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 0;
    endtask

    task automatic drain();
        idle();
        for (int k = 0; k < 10; k++) begin
            if (cnt == 0) break;
            mem_data_ok = 1;
            mem_rdata   = $urandom;
            step();
        end
        mem_data_ok = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        step();
        step();
        reset = 0;
    endtask

    task automatic chk_rlog(input int idx, input bit tag, input logic [31:0] rd);
        sb_t e;
        e.tag = ~tag;
        e.rd  = 32'hx;
        if (idx < rlog.size()) e = rlog[idx];
        chk1("resp_order_tag", e.tag, tag);
        chk32("resp_order_rdata", e.rd, rd);
    endtask

    initial begin
        logic [31:0] a;
        logic [3:0]  expn;
        reset = 1; idle();
        inst_addr = 0; inst_size = 0; data_wr = 0; data_size = 0; data_wstrb = 0;
        data_addr = 0; data_wdata = 0; mem_rdata = 0;
        cnt = 0; lk_v = 0; lk_o = 0; last = 0; err_m = 0;
        do_reset();

        // Both request with acceptance every cycle: data first, fetch after data drops.
        alog.delete();
        inst_req = 1; inst_addr = 32'h1000_0000; inst_size = 2'd2;
        data_req = 1; data_addr = 32'h2000_0000; data_wr = 1; data_wstrb = 4'hf;
        data_wdata = 32'hdead_beef; data_size = 2'd2; mem_addr_ok = 1;
        step();
        data_req = 0; mem_data_ok = 1; mem_rdata = 32'h0;
        step();
        drain();
        chk32("s1_count", 32'(alog.size()), 32'd2);
        chk32("s1_first", alog.size() > 0 ? alog[0] : 32'h0, 32'h2000_0000);
        chk32("s1_second", alog.size() > 1 ? alog[1] : 32'h0, 32'h1000_0000);

        // Stalled fetch keeps the port while data asserts.
        idle(); alog.delete();
        inst_req = 1; inst_addr = 32'h1000_0040; data_wr = 0;
        step();
        data_req = 1; data_addr = 32'h2000_0040;
        step(); chk32("s2_lock_c2", seen_addr, 32'h1000_0040);
        step(); chk32("s2_lock_c3", seen_addr, 32'h1000_0040);
        mem_addr_ok = 1;
        step(); chk32("s2_accept_c4", seen_addr, 32'h1000_0040);
        inst_req = 0;
        step(); chk32("s2_data_c5", seen_addr, 32'h2000_0040);
        drain();
        chk32("s2_accepts", 32'(alog.size()), 32'd2);

        // Fill to DEPTH, no bypass, then in-order responses.
        idle(); rlog.delete();
        inst_req = 1; inst_addr = 32'h1000_0080; mem_addr_ok = 1;
        step();
        inst_req = 0; data_req = 1; data_addr = 32'h2000_0080;
        step();
        inst_req = 1; data_addr = 32'h2000_00c0;
        step(); chk1("s3_full_blocks", seen_req, 1'b0);
        mem_data_ok = 1; mem_rdata = 32'h1111_1111;
        step(); chk1("s3_no_bypass", seen_req, 1'b0);
        inst_req = 0; data_req = 0; mem_rdata = 32'h2222_2222;
        step();
        mem_data_ok = 0;
        step();
        chk32("s3_resp_count", 32'(rlog.size()), 32'd2);
        chk_rlog(0, 1'b0, 32'h1111_1111);
        chk_rlog(1, 1'b1, 32'h2222_2222);

        // Push and pop together at count 1.
        idle(); rlog.delete();
        inst_req = 1; inst_addr = 32'h1000_0100; mem_addr_ok = 1;
        step();
        inst_req = 0; data_req = 1; data_addr = 32'h2000_0100;
        mem_data_ok = 1; mem_rdata = 32'h3333_3333;
        step();
        data_req = 0; inst_req = 1; inst_addr = 32'h1000_0140; mem_data_ok = 0;
        step();
        inst_req = 0; data_req = 1; data_addr = 32'h2000_0140;
        step(); chk1("s4_count_held", seen_req, 1'b0);
        data_req = 0; mem_data_ok = 1; mem_rdata = 32'h4444_4444;
        step();
        mem_rdata = 32'h5555_5555;
        step();
        mem_data_ok = 0;
        step();
        chk_rlog(0, 1'b0, 32'h3333_3333);
        chk_rlog(1, 1'b1, 32'h4444_4444);
        chk_rlog(2, 1'b0, 32'h5555_5555);

        // Continuous contention: round-robin alternates, fixed priority keeps data.
        idle(); alog.delete();
        inst_req = 1; inst_addr = 32'h3000_0000; data_req = 1; data_addr = 32'h4000_0000;
        mem_addr_ok = 1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (acc_f) inst_addr = inst_addr + 32'd4;
            if (acc_d) data_addr = data_addr + 32'd4;
            mem_data_ok = (cnt > 0);
        end
        drain();
        for (int i = 0; i < 8; i++) begin
            a = (i < alog.size()) ? alog[i] : 32'h0;
`ifdef SRAM_ARB_RR_EN
            expn = (i % 2 == 0) ? 4'h4 : 4'h3;
`else
            expn = 4'h4;
`endif
            chk32("s6_grant_seq", 32'(a[31:28]), 32'(expn));
        end

        // Randomized traffic; requesters hold their request until accepted.
        idle(); acc_f = 0; acc_d = 0;
        for (int n = 0; n < 3000; n++) begin
            if (!inst_req || acc_f) begin
                inst_req  = ($urandom % 3) != 0;
                inst_addr = $urandom;
                inst_size = 2'($urandom);
            end
            if (!data_req || acc_d) begin
                data_req   = ($urandom % 3) != 0;
                data_wr    = 1'($urandom);
                data_size  = 2'($urandom);
                data_wstrb = 4'($urandom);
                data_addr  = $urandom;
                data_wdata = $urandom;
            end
            mem_addr_ok = ($urandom % 4) != 0;
            mem_data_ok = (cnt > 0) && (($urandom % 2) == 1);
            mem_rdata   = $urandom;
            step();
        end

        // Reset with traffic possibly outstanding, then a response into an empty FIFO.
        do_reset();
        idle(); rlog.delete();
        mem_data_ok = 1; mem_rdata = 32'h6666_6666;
        step();
        mem_data_ok = 0;
        step(); chk1("s5_err_set", seen_err, 1'b1);
        step(); step(); chk1("s5_err_held", seen_err, 1'b1);
        chk32("s5_no_pulse", 32'(rlog.size()), 32'd0);
        reset = 1;
        step();
        reset = 0;
        step(); chk1("s5_err_cleared", seen_err, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
